instr_fetch_unit: RTL

Instruction fetch stage of the RISC-V core, sitting directly upstream of decode and the control unit. Holds the PC, issues word fetches to instruction memory, buffers returned instructions in a small in-order queue, and presents them with their PC to decode under a valid/ready handshake. Branch/jump resolution redirects it, flushing the queue and discarding stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RISC-V fetch stage with PC, in-order instruction queue and redirect flush.
// Optional FETCH_STATS_EN adds saturating fetched/discarded counters.
module instr_fetch_unit #(
  parameter int PC_W = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_discarded
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);
  typedef enum logic {BOOT, RUN} state_t;
  state_t r_state, w_state_nx;
  logic [PC_W-1:0] r_pc, r_resp_pc, w_tgt;
  logic [CW-1:0] r_cnt, r_out, r_disc;
  logic [PW-1:0] r_rd, r_wr;
  logic [INSTR_W-1:0] r_mem_i [DEPTH];
  logic [PC_W-1:0] r_mem_pc [DEPTH];
  logic w_issue, w_push, w_pop;
  always_comb begin
    w_state_nx = RUN;
    w_issue = r_state == RUN && !redirect_valid && ({1'b0, r_cnt} + {1'b0, r_out}) < LIM;
    imem_req = w_issue;
    imem_addr = r_pc;
  end
  assign w_tgt = redirect_pc & ~PC_W'(3);
  assign w_push = imem_rvalid && !redirect_valid && r_disc == '0;
  assign w_pop = instr_valid && instr_ready && !redirect_valid;
  assign instr_valid = r_cnt != '0;
  assign instr = r_mem_i[r_rd];
  assign instr_pc = r_mem_pc[r_rd];
  always_ff @(posedge clk) begin
    if (rst) r_state <= BOOT;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_cnt <= '0;
      r_out <= '0;
      r_disc <= '0;
      r_rd <= '0;
      r_wr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_i[i] <= '0;
        r_mem_pc[i] <= '0;
      end
    end else begin
      r_out <= r_out + CW'(w_issue) - CW'(imem_rvalid);
      if (redirect_valid) begin
        // every response still in flight after this cycle belongs to the old path
        r_pc <= w_tgt;
        r_resp_pc <= w_tgt;
        r_cnt <= '0;
        r_rd <= '0;
        r_wr <= '0;
        r_disc <= r_out - CW'(imem_rvalid);
      end else begin
        if (w_issue) r_pc <= r_pc + PC_W'(4);
        if (imem_rvalid && r_disc != '0) r_disc <= r_disc - CW'(1);
        if (w_push) begin
          r_mem_i[r_wr] <= imem_rdata;
          r_mem_pc[r_wr] <= r_resp_pc;
          r_wr <= r_wr + PW'(1);
          r_resp_pc <= r_resp_pc + PC_W'(4);
        end
        r_rd <= r_rd + PW'(w_pop);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(imem_rvalid && r_out == '0));
`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_f, r_stat_d;
  logic [CW:0] w_drop_n;
  logic [32:0] w_disc_sum;
  assign w_drop_n = redirect_valid ? {1'b0, r_cnt} + (CW+1)'(imem_rvalid)
                                   : (CW+1)'(imem_rvalid && r_disc != '0);
  assign w_disc_sum = {1'b0, r_stat_d} + 33'(w_drop_n);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_f <= '0;
      r_stat_d <= '0;
    end else begin
      if (w_pop && r_stat_f != '1) r_stat_f <= r_stat_f + 32'd1;
      r_stat_d <= w_disc_sum[32] ? '1 : w_disc_sum[31:0];
    end
  end
  assign stat_fetched = r_stat_f;
  assign stat_discarded = r_stat_d;
`endif
endmodule
